// File: rtl/mod_n_updown_counter.sv
// rtl/mod_n_updown_counter.sv - synchronous modulo-N up/down counter with load, tc flag and wrap pulse
// Optional feature: define MOD_CNT_SATURATE_EN to saturate at the bounds instead of wrapping.
module mod_n_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 10,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // Bounds held in WIDTH+1 bits so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   load_ext;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  assign count_ext = {1'b0, count};
  assign inc_ext   = count_ext + 1'b1;
  assign load_ext  = {1'b0, load_val};
  assign at_max    = (count == MAX_VAL);
  assign at_zero   = (count == '0);

  assign tc = en & ((up & at_max) | (~up & at_zero));

  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = (load_ext < MOD_EXT) ? load_val : MAX_VAL;
    end else if (en) begin
      if (up) begin
        if (inc_ext >= MOD_EXT) begin
`ifdef MOD_CNT_SATURATE_EN
          count_next = MAX_VAL;
`else
          count_next = '0;
          wrap_next  = 1'b1;
`endif
        end else begin
          count_next = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
`ifdef MOD_CNT_SATURATE_EN
          count_next = '0;
`else
          count_next = MAX_VAL;
          wrap_next  = 1'b1;
`endif
        end else begin
          count_next = count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= RST_VAL;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb/tb_mod_n_updown_counter.sv - directed self-checking bench for mod_n_updown_counter (WIDTH=4, MODULUS=10)
module tb_mod_n_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc;
  logic       wrap;

  int total;
  int bad;

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end want end");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++;
    if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %0b want 0", wrap); end
    total++;
    if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc: got %0b want 0", tc); end
    rst = 1'b1;
    en  = 1'b1;
    up  = 1'b1;
    repeat (7) step();
    total++;
    if (count !== 4'd7) begin bad++; $display("FAIL pre_reset_count: got %0d want 7", count); end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    total++;
    if (count !== 4'd0 || wrap !== 1'b0) begin
      bad++; $display("FAIL async_reset: got count=%0d wrap=%0b want count=0 wrap=0", count, wrap);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    total++;
    if (count !== 4'd1) begin bad++; $display("FAIL post_reset_count: got %0d want 1", count); end
    en = 1'b0;
  endtask

  task automatic test_count_up();
    int exp;
    do_reset();
    en = 1'b1;
    up = 1'b1;
    exp = 0;
    for (int i = 1; i <= 12; i++) begin
      total++;
      if (tc !== (exp == 9)) begin bad++; $display("FAIL up_tc[%0d]: got %0b want %0b", i, tc, exp == 9); end
      step();
      exp = i % 10;
      total++;
      if (count !== 4'(exp) || wrap !== (exp == 0)) begin
        bad++; $display("FAIL up_count[%0d]: got count=%0d wrap=%0b want count=%0d wrap=%0b", i, count, wrap, exp, exp == 0);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_count_down();
    do_reset();
    en = 1'b1;
    up = 1'b0;
    #1;
    total++;
    if (tc !== 1'b1) begin bad++; $display("FAIL down_tc_at_0: got %0b want 1", tc); end
`ifdef MOD_CNT_SATURATE_EN
    step();
    total++;
    if (count !== 4'd0 || wrap !== 1'b0) begin
      bad++; $display("FAIL down_sat: got count=%0d wrap=%0b want count=0 wrap=0", count, wrap);
    end
`else
    step();
    total++;
    if (count !== 4'd9 || wrap !== 1'b1) begin
      bad++; $display("FAIL down_wrap: got count=%0d wrap=%0b want count=9 wrap=1", count, wrap);
    end
    step();
    total++;
    if (count !== 4'd8 || wrap !== 1'b0) begin
      bad++; $display("FAIL down_8: got count=%0d wrap=%0b want count=8 wrap=0", count, wrap);
    end
    step();
    total++;
    if (count !== 4'd7 || wrap !== 1'b0) begin
      bad++; $display("FAIL down_7: got count=%0d wrap=%0b want count=7 wrap=0", count, wrap);
    end
`endif
    en = 1'b0;
  endtask

  task automatic test_load();
    logic [3:0] vals [5] = '{4'd12, 4'd3, 4'd10, 4'd15, 4'd9};
    logic [3:0] exps [5] = '{4'd9, 4'd3, 4'd9, 4'd9, 4'd9};
    en   = 1'b1;
    up   = 1'b1;
    load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_val = vals[i];
      step();
      total++;
      if (count !== exps[i] || wrap !== 1'b0) begin
        bad++; $display("FAIL load[%0d]: got count=%0d wrap=%0b want count=%0d wrap=0", vals[i], count, wrap, exps[i]);
      end
    end
    load = 1'b0;
    en   = 1'b0;
  endtask

  task automatic test_back_to_back();
    load     = 1'b1;
    load_val = 4'd9;
    step();
    load = 1'b0;
    en   = 1'b1;
    up   = 1'b1;
    #1;
    total++;
    if (tc !== 1'b1) begin bad++; $display("FAIL b2b_tc_up: got %0b want 1", tc); end
    step();
    total++;
    if (count !== 4'd0 || wrap !== 1'b1) begin
      bad++; $display("FAIL b2b_first: got count=%0d wrap=%0b want count=0 wrap=1", count, wrap);
    end
    up = 1'b0;
    #1;
    total++;
    if (tc !== 1'b1) begin bad++; $display("FAIL b2b_tc_down: got %0b want 1", tc); end
    step();
    total++;
    if (count !== 4'd9 || wrap !== 1'b1) begin
      bad++; $display("FAIL b2b_second: got count=%0d wrap=%0b want count=9 wrap=1", count, wrap);
    end
    en = 1'b0;
    #1;
    total++;
    if (tc !== 1'b0) begin bad++; $display("FAIL hold_tc: got %0b want 0", tc); end
    step();
    total++;
    if (count !== 4'd9 || wrap !== 1'b0) begin
      bad++; $display("FAIL hold: got count=%0d wrap=%0b want count=9 wrap=0", count, wrap);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] exps [4] = '{4'd9, 4'd9, 4'd9, 4'd9};
    load     = 1'b1;
    load_val = 4'd8;
    step();
    load = 1'b0;
    en   = 1'b1;
    up   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (count !== exps[i] || wrap !== 1'b0 || tc !== 1'b1) begin
        bad++; $display("FAIL sat_up[%0d]: got count=%0d wrap=%0b tc=%0b want count=9 wrap=0 tc=1", i, count, wrap, tc);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = 4'd0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
`ifdef MOD_CNT_SATURATE_EN
    test_saturate();
`else
    test_back_to_back();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
